uart_tx_fifo_ctrl: RTL and testbench
====================================

// Module: uart_tx_fifo_ctrl
// PURPOSE
//  Buffered front end for the UART transmitter, in the TX clock domain.
//  Host pushes bytes into a synchronous FIFO. A small FSM pops one byte at a time
//  and presents it to the transmitter as P_DATA plus a one-cycle Data_Valid.
//  It then holds off until the transmitter's busy flag has risen and fallen again.
// PARAMETERS
//  DATA_WIDTH   8  width of one character, equal to the transmitter data width
//  ADDR_WIDTH   3  FIFO address bits; depth = 2**ADDR_WIDTH (default 8 entries)
// PORTS
//  CLK            in   1             TX clock; sole clock of the block
//  RST            in   1             asynchronous, active-low reset
//  WR_DATA        in   DATA_WIDTH    byte to enqueue
//  WR_EN          in   1             push strobe, sampled on rising CLK
//  FULL           out  1             FIFO holds 2**ADDR_WIDTH entries
//  EMPTY          out  1             FIFO holds 0 entries
//  COUNT          out  ADDR_WIDTH+1  current occupancy
//  OVERFLOW       out  1             sticky: a push was dropped because FIFO was FULL
//  OVF_CLR        in   1             synchronous clear of OVERFLOW
//  TX_BUSY        in   1             busy flag from the transmitter
//  TX_P_DATA      out  DATA_WIDTH    byte presented to the transmitter
//  TX_DATA_VALID  out  1             one-cycle strobe; TX_P_DATA is valid while high
// BEHAVIOUR
//  Reset (RST=0, async): pointers=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0.
//   TX_P_DATA=0, TX_DATA_VALID=0, FSM=IDLE. Memory contents are not reset.
//  FULL and EMPTY are decoded from the registered COUNT. COUNT changes one cycle after push/pop.
//  Push: WR_EN & !FULL -> mem[wptr]<=WR_DATA, wptr+1, wrapping modulo depth.
//  Push with FULL: data dropped, OVERFLOW<=1. A same-cycle pop does not rescue it.
//  OVF_CLR & overflowing push in the same cycle: OVERFLOW stays 1 (set wins).
//  Push and pop in the same cycle (not FULL): both happen, and COUNT is unchanged.
//  FSM states (2-bit, encoded in the shared include):
//   IDLE      : if !EMPTY & !TX_BUSY -> pop, latching TX_P_DATA<=mem[rptr] and rptr+1 -> ISSUE.
//   ISSUE     : TX_DATA_VALID=1 for exactly this cycle. Clear the guard counter -> WAIT_BUSY.
//   WAIT_BUSY : TX_BUSY=1 -> WAIT_DONE.
//               Otherwise increment the 2-bit guard; at guard==3 -> IDLE (lost handshake, no retry).
//   WAIT_DONE : TX_BUSY=0 -> IDLE.
//  TX_DATA_VALID is registered and high only in ISSUE, never two cycles back to back.
//  TX_P_DATA holds the last popped byte until the next pop.
//  Latency: push at edge n into an empty FIFO with TX_BUSY=0 -> EMPTY=0 after edge n+1.
//   Pop at edge n+2, TX_DATA_VALID high in cycle n+2..n+3.
//  Back-to-back bytes: the next pop is no earlier than the first IDLE cycle after TX_BUSY falls.
//  Reset mid-frame: all state returns to reset values immediately.
//   Queued bytes are discarded and TX_DATA_VALID drops asynchronously.
//  Wrap-around: pointers are ADDR_WIDTH bits and free-run modulo depth. COUNT never exceeds depth.
// STRUCTURE
//  uart_defines.vh (shared by all UART blocks):
//   FSM state localparams IDLE/ISSUE/WAIT_BUSY/WAIT_DONE, guard limit 3.
//  Sub-module uart_fifo_mem: 2**ADDR_WIDTH x DATA_WIDTH register array.
//   One write port, one combinational read port, no reset.
//  Top level holds pointers, COUNT, OVERFLOW, FSM and the output registers.
// TESTING
//  1 Reset: drive RST=0 mid-transfer with 3 bytes queued -> all outputs at reset values.
//    After release, EMPTY=1 and no TX_DATA_VALID.
//  2 Single byte: push 0xA5 with TX_BUSY=0 -> TX_DATA_VALID 1 cycle, exactly 2 edges after push.
//    TX_P_DATA=0xA5.
//  3 Back-pressure: model TX_BUSY high 1 cycle after valid for 10 cycles; push 0x01,0x02,0x03.
//    Three valids in order, each in or after the first IDLE cycle following a TX_BUSY fall.
//  4 Full/overflow: with TX_BUSY held 1, push 9 bytes 0x10..0x18.
//    FULL=1 and COUNT=8 after the 8th push; the 9th is dropped and OVERFLOW=1.
//    OVF_CLR clears OVERFLOW; on release 0x10..0x17 go out in order.
//  5 Simultaneous push/pop at COUNT=4: COUNT stays 4. Pointer wrap: 20 bytes through -> order preserved.
//  6 Lost handshake: TX_BUSY tied 0 after valid -> FSM returns to IDLE after 3 WAIT_BUSY cycles.
//    The next byte is then issued.

Source files
------------

// File: rtl/uart_tx_fifo_ctrl_pkg.sv
// uart_tx_fifo_ctrl_pkg: shared FSM states and handshake guard limit for the UART TX front end
package uart_tx_fifo_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;
  localparam logic [1:0] GUARD_LIMIT = 2'd3;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: unreset register array, one write port and one combinational read port
module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  // write port; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: byte FIFO feeding the UART transmitter with a busy-flag handshake
module uart_tx_fifo_ctrl
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_en_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  input  logic                  ovf_clr_i,
  input  logic                  tx_busy_i,
  output logic [DATA_WIDTH-1:0] tx_p_data_o,
  output logic                  tx_data_valid_o
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d, valid_q, valid_d, push, pop;
  logic [DATA_WIDTH-1:0] data_q, data_d, rdata;
  logic [1:0]            guard_q, guard_d;
  tx_state_e             state_q, state_d;

  uart_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  assign full_o          = count_q == DEPTH;
  assign empty_o         = count_q == '0;
  assign count_o         = count_q;
  assign overflow_o      = ovf_q;
  assign tx_p_data_o     = data_q;
  assign tx_data_valid_o = valid_q;

  // FIFO bookkeeping: a push into a full FIFO is dropped and sets the sticky flag, which beats a clear
  always_comb begin
    push    = wr_en_i & ~full_o;
    pop     = (state_q == IDLE) & ~empty_o & ~tx_busy_i;
    wptr_d  = wptr_q + ADDR_WIDTH'(push);
    rptr_d  = rptr_q + ADDR_WIDTH'(pop);
    count_d = count_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
    ovf_d   = (wr_en_i & full_o) | (ovf_q & ~ovf_clr_i);
    data_d  = pop ? rdata : data_q;
    valid_d = pop;
  end

  // handshake FSM: issue one byte, then wait for busy to rise and fall, or give up after the guard expires
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    case (state_q)
      IDLE:      state_d = pop ? ISSUE : IDLE;
      ISSUE: begin
        guard_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        guard_d = tx_busy_i ? guard_q : guard_q + 2'd1;
        state_d = tx_busy_i ? WAIT_DONE : (guard_q + 2'd1 == GUARD_LIMIT) ? IDLE : WAIT_BUSY;
      end
      WAIT_DONE: state_d = tx_busy_i ? WAIT_DONE : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // state and output registers; reset discards queued bytes and drops the strobe immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      guard_q <= '0;
      state_q <= IDLE;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      guard_q <= guard_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb_uart_tx_fifo_ctrl: directed bench with a queue-based reference model checked every cycle
module tb_uart_tx_fifo_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0, ovf_clr = 1'b0, tx_busy = 1'b0;
  logic       full, empty, overflow, valid;
  logic [3:0] count;
  logic [7:0] p_data;

  uart_tx_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_data_i       (wr_data),
    .wr_en_i         (wr_en),
    .full_o          (full),
    .empty_o         (empty),
    .count_o         (count),
    .overflow_o      (overflow),
    .ovf_clr_i       (ovf_clr),
    .tx_busy_i       (tx_busy),
    .tx_p_data_o     (p_data),
    .tx_data_valid_o (valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0, busy_left = 0;
  bit auto_tx = 1'b0;
  logic [7:0] got_q[$];
  int vcyc_q[$];

  always @(posedge clk) cyc++;

  // Reference model: FIFO as a queue; after each issued byte the sender is blocked until the
  // transmitter's busy flag has been seen high then low, or 3 cycles pass without busy rising.
  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0, m_issue = 1'b0, m_blocked = 1'b0, m_seen = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_wait = 0;
  bit         m_full, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 0; m_issue = 0; m_blocked = 0; m_seen = 0; m_wait = 0; m_data = 8'h00;
    end else begin
      m_full = m_q.size() == 8;
      m_pop  = !m_issue && !m_blocked && m_q.size() > 0 && !tx_busy;
      if (wr_en && m_full) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (m_issue) begin
        m_issue = 0; m_blocked = 1; m_seen = 0; m_wait = 0;
      end else if (m_blocked) begin
        if (m_seen) begin
          if (!tx_busy) m_blocked = 0;
        end else if (tx_busy) m_seen = 1;
        else begin
          m_wait++;
          if (m_wait == 3) m_blocked = 0;
        end
      end else if (m_pop) begin
        m_data  = m_q.pop_front();
        m_issue = 1;
      end
      if (wr_en && !m_full) m_q.push_back(wr_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // per-cycle comparison against the model, plus a log of every issued byte
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(m_q.size()));
    chk("full", 32'(full), 32'(m_q.size() == 8));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("valid", 32'(valid), 32'(m_issue));
    chk("p_data", 32'(p_data), 32'(m_data));
    if (valid === 1'b1) begin
      got_q.push_back(p_data);
      vcyc_q.push_back(cyc);
    end
  end

  // advance n cycles; in auto mode act as a transmitter that is busy for 10 cycles after each valid
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
      if (auto_tx) begin
        tx_busy = busy_left > 0;
        if (busy_left > 0) busy_left--;
        if (valid === 1'b1) busy_left = 10;
      end
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && (m_q.size() > 0 || m_issue || m_blocked || busy_left > 0); k++) step(1);
    step(2);
    chk("drain_empty", 32'(count), 0);
  endtask

  task automatic clear_log();
    got_q.delete();
    vcyc_q.delete();
  endtask

  initial begin
    int pc;
    step(2);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_valid", 32'(valid), 0);
    rst_n = 1'b1;
    step(2);

    // single byte with TX_BUSY low: strobe two edges after the push is driven
    clear_log();
    pc = cyc;
    push(8'hA5);
    step(6);
    chk("t2_nvalid", 32'(got_q.size()), 1);
    chk("t2_data", 32'(got_q[0]), 32'h A5);
    chk("t2_latency", 32'(vcyc_q[0] - pc), 2);
    drain();

    // back-pressure: busy for 10 cycles after each valid
    auto_tx = 1'b1;
    clear_log();
    push(8'h01); push(8'h02); push(8'h03);
    drain();
    chk("t3_nvalid", 32'(got_q.size()), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t3_byte%0d", i), 32'(got_q[i]), 32'(i + 1));
    chk("t3_gap01", 32'(vcyc_q[1] - vcyc_q[0]), 13);
    chk("t3_gap12", 32'(vcyc_q[2] - vcyc_q[1]), 13);

    // full and overflow with the transmitter stalled
    auto_tx = 1'b0;
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    chk("t4_count8", 32'(count), 8);
    chk("t4_full", 32'(full), 1);
    chk("t4_ovf0", 32'(overflow), 0);
    push(8'h18);
    chk("t4_ovf1", 32'(overflow), 1);
    chk("t4_count_still8", 32'(count), 8);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 0);
    clear_log();
    auto_tx = 1'b1;
    drain();
    chk("t4_nvalid", 32'(got_q.size()), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t4_byte%0d", i), 32'(got_q[i]), 32'(8'h10 + 8'(i)));

    // simultaneous push and pop at COUNT=4, then 20 bytes through the wrapping pointers
    auto_tx = 1'b0;
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    chk("t5_count4", 32'(count), 4);
    wr_en = 1'b1;
    wr_data = 8'h44;
    tx_busy = 1'b0;
    step(1);
    wr_en = 1'b0;
    chk("t5_count_same", 32'(count), 4);
    chk("t5_valid", 32'(valid), 1);
    chk("t5_pdata", 32'(p_data), 32'h40);
    clear_log();
    auto_tx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 200 && m_q.size() >= 6; k++) step(1);
      push(8'h50 + 8'(i));
    end
    drain();
    chk("t5_nvalid", 32'(got_q.size()), 24);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_byte%0d", i), 32'(got_q[i]), 32'(8'h41 + 8'(i)));
    for (int i = 0; i < 20; i++) chk($sformatf("t5_wrap%0d", i), 32'(got_q[i + 4]), 32'(8'h50 + 8'(i)));

    // lost handshake: busy never rises, the guard releases the FSM after 3 cycles
    auto_tx = 1'b0;
    tx_busy = 1'b0;
    clear_log();
    push(8'h77);
    push(8'h88);
    drain();
    chk("t6_nvalid", 32'(got_q.size()), 2);
    chk("t6_byte0", 32'(got_q[0]), 32'h77);
    chk("t6_byte1", 32'(got_q[1]), 32'h88);
    chk("t6_gap", 32'(vcyc_q[1] - vcyc_q[0]), 5);

    // reset in the middle of a transfer with bytes still queued
    auto_tx = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) push(8'h91 + 8'(i));
    for (int k = 0; k < 100 && got_q.size() == 0; k++) step(1);
    chk("t1_started", 32'(got_q.size()), 1);
    chk("t1_queued", 32'(count), 3);
    rst_n = 1'b0;
    #1;
    chk("t1_valid0", 32'(valid), 0);
    chk("t1_count0", 32'(count), 0);
    chk("t1_empty1", 32'(empty), 1);
    chk("t1_full0", 32'(full), 0);
    chk("t1_ovf0", 32'(overflow), 0);
    chk("t1_pdata0", 32'(p_data), 0);
    step(2);
    auto_tx = 1'b0;
    busy_left = 0;
    tx_busy = 1'b0;
    rst_n = 1'b1;
    clear_log();
    step(20);
    chk("t1_no_valid", 32'(got_q.size()), 0);
    chk("t1_empty_after", 32'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
